// File: rtl/fp_divider.sv
// IEEE-754 single-precision divider, restoring radix-2, one quotient bit per clock.
// Latency: 27 cycles accept-to-out_valid (29 with FP_DIV_RNE_EN); special operands 1 cycle.
// Backpressure: result/out_valid held while !out_ready; in_ready low until the cycle after the output handshake.
//
// Ports:
//   clk, reset_n          - clock, asynchronous active-low reset
//   in_valid/in_ready     - operand handshake; dataa = dividend, datab = divisor
//   out_valid/out_ready   - result handshake; result = quotient (registered)
// Build option: define FP_DIV_RNE_EN for round-to-nearest-even (27 iterations);
// otherwise the quotient is truncated (25 iterations).
module fp_divider (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result
);

`ifdef FP_DIV_RNE_EN
  localparam int ITERS = 27;
`else
  localparam int ITERS = 25;
`endif
  localparam logic [4:0] LAST_ITER = 5'(ITERS - 1);

  typedef enum logic [1:0] {IDLE, DIVIDE, NORM, DONE} state_t;

  state_t             state_q, state_d;
  logic               sign_q, sign_d;
  logic [7:0]         ea_q, ea_d;
  logic [7:0]         eb_q, eb_d;
  logic [23:0]        mb_q, mb_d;
  logic [24:0]        rem_q, rem_d;
  logic [ITERS-1:0]   q_q, q_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [31:0]        result_q, result_d;
  logic               out_valid_q, out_valid_d;
  logic               in_ready_q, in_ready_d;

  // Operand classification (denormals count as zero)
  logic [7:0] a_exp, b_exp;
  logic       a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, sign_in;
  assign a_exp   = dataa[30:23];
  assign b_exp   = datab[30:23];
  assign a_nan   = (&a_exp) &  (|dataa[22:0]);
  assign b_nan   = (&b_exp) &  (|datab[22:0]);
  assign a_inf   = (&a_exp) & ~(|dataa[22:0]);
  assign b_inf   = (&b_exp) & ~(|datab[22:0]);
  assign a_zero  = (a_exp == 8'd0);
  assign b_zero  = (b_exp == 8'd0);
  assign sign_in = dataa[31] ^ datab[31];

  // One restoring step. rem stays below 2*mb, so the shifted value fits 25 bits.
  logic        rem_ge;
  logic [24:0] rem_sub;
  assign rem_ge  = (rem_q >= {1'b0, mb_q});
  assign rem_sub = rem_ge ? (rem_q - {1'b0, mb_q}) : rem_q;

  // Normalisation: q top bit has weight 2^0; if clear the quotient is in [0.5,1).
  logic               q_top;
  logic [22:0]        frac_t, frac_f;
  logic signed [9:0]  e_base, e_f;
  logic [31:0]        norm_res;
  assign q_top  = q_q[ITERS-1];
  assign frac_t = q_top ? q_q[ITERS-2 -: 23] : q_q[ITERS-3 -: 23];
  assign e_base = {2'b00, ea_q} - {2'b00, eb_q} + 10'd127 - {9'd0, ~q_top};

`ifdef FP_DIV_RNE_EN
  logic        guard, sticky, round_up;
  logic [24:0] mant_r;
  assign guard    = q_top ? q_q[2] : q_q[1];
  assign sticky   = (q_top ? (|q_q[1:0]) : q_q[0]) | (|rem_q);
  assign round_up = guard & (sticky | frac_t[0]);
  assign mant_r   = {2'b01, frac_t} + {24'd0, round_up};
  // A carry out of the mantissa means 2.0: fraction becomes zero, exponent bumps.
  assign frac_f   = mant_r[24] ? mant_r[23:1] : mant_r[22:0];
  assign e_f      = e_base + {9'd0, mant_r[24]};
`else
  assign frac_f   = frac_t;
  assign e_f      = e_base;
`endif

  always_comb begin
    norm_res = {sign_q, e_f[7:0], frac_f};
    if (e_f > 10'sd254) begin
      norm_res = {sign_q, 8'hFF, 23'd0};
    end else if (e_f < 10'sd1) begin
      norm_res = {sign_q, 31'd0};
    end
  end

  // Special-case result, in priority order
  logic        special_hit;
  logic [31:0] special_val;
  always_comb begin
    special_hit = 1'b1;
    special_val = 32'd0;
    if (a_nan) begin
      special_val = dataa;
    end else if (b_nan) begin
      special_val = datab;
    end else if ((a_zero & b_zero) | (a_inf & b_inf)) begin
      special_val = 32'h7FC0_0000;
    end else if (b_zero | a_inf) begin
      special_val = {sign_in, 8'hFF, 23'd0};
    end else if (b_inf | a_zero) begin
      special_val = {sign_in, 31'd0};
    end else begin
      special_hit = 1'b0;
    end
  end

  always_comb begin
    state_d     = state_q;
    sign_d      = sign_q;
    ea_d        = ea_q;
    eb_d        = eb_q;
    mb_d        = mb_q;
    rem_d       = rem_q;
    q_d         = q_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          sign_d     = sign_in;
          ea_d       = a_exp;
          eb_d       = b_exp;
          mb_d       = {1'b1, datab[22:0]};
          rem_d      = {2'b01, dataa[22:0]};
          q_d        = '0;
          cnt_d      = 5'd0;
          in_ready_d = 1'b0;
          if (special_hit) begin
            result_d    = special_val;
            out_valid_d = 1'b1;
            state_d     = DONE;
          end else begin
            state_d = DIVIDE;
          end
        end
      end
      DIVIDE: begin
        rem_d = {rem_sub[23:0], 1'b0};
        q_d   = {q_q[ITERS-2:0], rem_ge};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == LAST_ITER) begin
          state_d = NORM;
        end
      end
      NORM: begin
        result_d    = norm_res;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      sign_q      <= 1'b0;
      ea_q        <= 8'd0;
      eb_q        <= 8'd0;
      mb_q        <= 24'd0;
      rem_q       <= 25'd0;
      q_q         <= '0;
      cnt_q       <= 5'd0;
      result_q    <= 32'd0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      sign_q      <= sign_d;
      ea_q        <= ea_d;
      eb_q        <= eb_d;
      mb_q        <= mb_d;
      rem_q       <= rem_d;
      q_q         <= q_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;

endmodule

// File: tb/tb_fp_divider.sv
module tb_fp_divider;

`ifdef FP_DIV_RNE_EN
  localparam int          NLAT    = 29;
  localparam logic [31:0] EXP_1_3 = 32'h3EAA_AAAB;
  localparam logic [31:0] EXP_2_3 = 32'h3F2A_AAAB;
`else
  localparam int          NLAT    = 27;
  localparam logic [31:0] EXP_1_3 = 32'h3EAA_AAAA;
  localparam logic [31:0] EXP_2_3 = 32'h3F2A_AAAA;
`endif
  localparam int NV = 18;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] dataa = 32'd0;
  logic [31:0] datab = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  fp_divider dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dataa     (dataa),
    .datab     (datab),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Directed vectors: dividend, divisor, expected quotient, expected latency
  logic [31:0] va   [NV];
  logic [31:0] vb   [NV];
  logic [31:0] vexp [NV];
  int          vlat [NV];

  task automatic set_vec(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] e, input int l);
    va[i] = a; vb[i] = b; vexp[i] = e; vlat[i] = l;
  endtask

  // Issue one job from IDLE (called #1 after an edge), wait for out_valid, check, handshake.
  task automatic run_job(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] e, input int l);
    int lat;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    dataa = a; datab = b; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    dataa = $urandom; datab = $urandom;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(l));
    chk({tag, "_res"}, result, e);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_post_vld"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    set_vec(0,  32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, NLAT); // 6/2
    set_vec(1,  32'h3F80_0000, 32'h4040_0000, EXP_1_3,       NLAT); // 1/3
    set_vec(2,  32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000, 1);    // -1/0
    set_vec(3,  32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 1);    // 0/0
    set_vec(4,  32'h7F80_0000, 32'h7F80_0000, 32'h7FC0_0000, 1);    // inf/inf
    set_vec(5,  32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0001, 1);    // NaN/1
    set_vec(6,  32'h7F00_0000, 32'h3E80_0000, 32'h7F80_0000, NLAT); // overflow
    set_vec(7,  32'h0080_0000, 32'h4000_0000, 32'h0000_0000, NLAT); // underflow
    set_vec(8,  32'h3F80_0000, 32'hFFC0_0002, 32'hFFC0_0002, 1);    // 1/NaN
    set_vec(9,  32'h7FC0_0001, 32'h7FC0_0002, 32'h7FC0_0001, 1);    // a NaN wins
    set_vec(10, 32'h4000_0000, 32'hFF80_0000, 32'h8000_0000, 1);    // 2/-inf
    set_vec(11, 32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 1);    // -inf/2
    set_vec(12, 32'h0000_0000, 32'hC040_0000, 32'h8000_0000, 1);    // 0/-3
    set_vec(13, 32'h0000_0001, 32'h3F80_0000, 32'h0000_0000, 1);    // denormal/1
    set_vec(14, 32'h7F80_0000, 32'h0000_0000, 32'h7F80_0000, 1);    // inf/0
    set_vec(15, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, NLAT); // 1/1
    set_vec(16, 32'hC0F0_0000, 32'h4020_0000, 32'hC040_0000, NLAT); // -7.5/2.5
    set_vec(17, 32'h3F80_0000, 32'h3FC0_0000, EXP_2_3,       NLAT); // 1/1.5
  end

  initial begin
    int lat;
    logic [31:0] held;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", result, 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      run_job($sformatf("vec%0d", i), va[i], vb[i], vexp[i], vlat[i]);
    end

    // Backpressure: hold the 6/2 result for 10 cycles while a new job is offered.
    dataa = 32'h40C0_0000; datab = 32'h4000_0000; in_valid = 1'b1;
    @(posedge clk); #1;
    dataa = 32'h3F80_0000; datab = 32'h4040_0000;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp_lat", 32'(lat), 32'(NLAT));
    chk("bp_res", result, 32'h4040_0000);
    held = result;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk("bp_hold_res", result, held);
      chk("bp_hold_vld", 32'(out_valid), 32'd1);
      chk("bp_hold_rdy", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_idle_rdy", 32'(in_ready), 32'd1);
    chk("bp_idle_vld", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_next_accepted", 32'(in_ready), 32'd0);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp_next_lat", 32'(lat), 32'(NLAT));
    chk("bp_next_res", result, EXP_1_3);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset in the middle of a job.
    dataa = 32'h40C0_0000; datab = 32'h4000_0000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_vld", 32'(out_valid), 32'd0);
    chk("mid_rst_res", result, 32'd0);
    chk("mid_rst_rdy", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_vld", 32'(out_valid), 32'd0);
    run_job("post_rst", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, NLAT);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
